// File: rtl/vec_cache_req_merge_arb.sv
// Per-channel request merge stage. The read and write crossbar outputs each
// feed their own small FIFO. One request per cycle goes to the tag pipeline.
// Reads win by default. A starvation counter and a full write FIFO force a
// write grant. A grant that stalls is locked until the tag pipeline accepts it.
module vec_cache_req_merge_arb #(
    parameter int PLD_WIDTH    = 128,
    parameter int RD_DEPTH     = 4,
    parameter int WR_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_req_vld,
    input  logic [PLD_WIDTH-1:0]        rd_req_pld,
    output logic                        rd_req_rdy,
    input  logic                        wr_req_vld,
    input  logic [PLD_WIDTH-1:0]        wr_req_pld,
    output logic                        wr_req_rdy,
    output logic                        out_vld,
    output logic [PLD_WIDTH-1:0]        out_pld,
    output logic                        out_is_wr,
    input  logic                        out_rdy,
    output logic [$clog2(RD_DEPTH):0]   rd_cnt,
    output logic [$clog2(WR_DEPTH):0]   wr_cnt
);

    localparam int RD_AW = $clog2(RD_DEPTH);
    localparam int WR_AW = $clog2(WR_DEPTH);
    localparam int RD_CW = RD_AW + 1;
    localparam int WR_CW = WR_AW + 1;

    logic [PLD_WIDTH-1:0] rd_mem [RD_DEPTH];
    logic [PLD_WIDTH-1:0] wr_mem [WR_DEPTH];
    logic [RD_AW-1:0]     rd_wptr, rd_rptr;
    logic [WR_AW-1:0]     wr_wptr, wr_rptr;

    logic [7:0]           starve_cnt;
    logic                 lock_vld;
    logic                 lock_is_wr;
    logic                 sel_wr;

    logic                 rd_push, rd_pop, wr_push, wr_pop, fire;

    // Ready comes from the registered count only, so a same-cycle pop
    // never re-opens a full FIFO.
    assign rd_req_rdy = (rd_cnt < RD_CW'(RD_DEPTH));
    assign wr_req_rdy = (wr_cnt < WR_CW'(WR_DEPTH));

    assign rd_push = rd_req_vld && rd_req_rdy;
    assign wr_push = wr_req_vld && wr_req_rdy;
    assign fire    = out_vld && out_rdy;
    assign rd_pop  = fire && !sel_wr;
    assign wr_pop  = fire && sel_wr;

    // Arbitration from the FIFO heads; a locked grant overrides a fresh decision.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_wr = 1'b0;
        if (lock_vld)
            sel_wr = lock_is_wr;
        else if (rd_cnt == '0)
            sel_wr = (wr_cnt != '0);
        else if (wr_cnt != '0)
            sel_wr = (starve_cnt == 8'(STARVE_LIMIT)) || (wr_cnt == WR_CW'(WR_DEPTH));
    end

    assign out_vld   = (rd_cnt != '0) || (wr_cnt != '0);
    assign out_is_wr = out_vld && sel_wr;
    assign out_pld   = sel_wr ? wr_mem[wr_rptr] : rd_mem[rd_rptr];

    // Payload storage for both FIFOs.
    always_ff @(posedge clk) begin
        // NOTE: the storage arrays are left out of reset on purpose; the
        // counts alone say which entries are valid, and unreset arrays map
        // onto plain RAM/flop banks without a reset tree.
        if (rd_push) rd_mem[rd_wptr] <= rd_req_pld;
        if (wr_push) wr_mem[wr_wptr] <= wr_req_pld;
    end

    // Read FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register here samples pre-edge values, whatever the statement order.
        if (rst) begin
            rd_wptr <= '0;
            rd_rptr <= '0;
            rd_cnt  <= '0;
        end else begin
            if (rd_push) rd_wptr <= rd_wptr + RD_AW'(1);
            if (rd_pop)  rd_rptr <= rd_rptr + RD_AW'(1);
            case ({rd_push, rd_pop})
                2'b10:   rd_cnt <= rd_cnt + RD_CW'(1);
                2'b01:   rd_cnt <= rd_cnt - RD_CW'(1);
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    // Write FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_wptr <= '0;
            wr_rptr <= '0;
            wr_cnt  <= '0;
        end else begin
            if (wr_push) wr_wptr <= wr_wptr + WR_AW'(1);
            if (wr_pop)  wr_rptr <= wr_rptr + WR_AW'(1);
            case ({wr_push, wr_pop})
                2'b10:   wr_cnt <= wr_cnt + WR_CW'(1);
                2'b01:   wr_cnt <= wr_cnt - WR_CW'(1);
                default: wr_cnt <= wr_cnt;
            endcase
        end
    end

    // Grant lock: freeze the selection while the tag pipeline stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld   <= 1'b0;
            lock_is_wr <= 1'b0;
        end else if (out_vld && !out_rdy) begin
            lock_vld   <= 1'b1;
            lock_is_wr <= sel_wr;
        end else if (fire) begin
            lock_vld   <= 1'b0;
            lock_is_wr <= 1'b0;
        end
    end

    // Starvation counter: counts reads that bypass a waiting write.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (wr_pop)
            starve_cnt <= '0;
        else if (rd_pop && (wr_cnt != '0) && (starve_cnt != 8'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + 8'd1;
    end

    a_rd_no_push_full: assert property (@(posedge clk) !(!rst && rd_push && rd_cnt == RD_CW'(RD_DEPTH)));
    a_wr_no_push_full: assert property (@(posedge clk) !(!rst && wr_push && wr_cnt == WR_CW'(WR_DEPTH)));
    a_rd_no_pop_empty: assert property (@(posedge clk) !(!rst && rd_pop && rd_cnt == '0));
    a_wr_no_pop_empty: assert property (@(posedge clk) !(!rst && wr_pop && wr_cnt == '0));
    a_out_stable:      assert property (@(posedge clk)
        (!rst && out_vld && !out_rdy) |=> (rst || (out_vld && $stable(out_pld) && $stable(out_is_wr))));

endmodule

// File: tb/tb_vec_cache_req_merge_arb.sv
// Scoreboard bench for vec_cache_req_merge_arb: expected grants are queued as
// stimulus is driven and compared in order as the DUT hands them out.
module tb_vec_cache_req_merge_arb;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req_vld = 1'b0, wr_req_vld = 1'b0, out_rdy = 1'b0;
    logic [W-1:0] rd_req_pld = '0, wr_req_pld = '0;
    logic         rd_req_rdy, wr_req_rdy, out_vld, out_is_wr;
    logic [W-1:0] out_pld;
    logic [2:0]   rd_cnt, wr_cnt;

    typedef struct packed {
        logic [W-1:0] pld;
        logic         is_wr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   idx;
    logic acc;

    vec_cache_req_merge_arb #(
        .PLD_WIDTH(W), .RD_DEPTH(4), .WR_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_vld(rd_req_vld), .rd_req_pld(rd_req_pld), .rd_req_rdy(rd_req_rdy),
        .wr_req_vld(wr_req_vld), .wr_req_pld(wr_req_pld), .wr_req_rdy(wr_req_rdy),
        .out_vld(out_vld), .out_pld(out_pld), .out_is_wr(out_is_wr), .out_rdy(out_rdy),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rdp(input int i);
        return {96'h0, 32'hA000_0000 + 32'(i)};
    endfunction

    function automatic logic [W-1:0] wrp(input int i);
        return {96'h0, 32'hB000_0000 + 32'(i)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [W-1:0] pld, input logic is_wr);
        exp_q.push_back('{pld: pld, is_wr: is_wr});
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check(tag, W'(exp_q.size()), '0);
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", W'(out_vld), '0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_pld", out_pld, e.pld);
                check("out_is_wr", W'(out_is_wr), W'(e.is_wr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset then idle.
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_rd_rdy", W'(rd_req_rdy), W'(1));
        check("rst_wr_rdy", W'(wr_req_rdy), W'(1));
        check("rst_out_vld", W'(out_vld), '0);
        check("rst_out_is_wr", W'(out_is_wr), '0);
        check("rst_rd_cnt", W'(rd_cnt), '0);
        check("rst_wr_cnt", W'(wr_cnt), '0);

        // Fill the read FIFO while stalled, then drain in order.
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_req_vld = 1'b1;
            rd_req_pld = rdp(i);
            step();
            expect_out(rdp(i), 1'b0);
        end
        rd_req_vld = 1'b0;
        check("full_rd_cnt", W'(rd_cnt), W'(4));
        check("full_rd_rdy", W'(rd_req_rdy), '0);
        check("full_out_vld", W'(out_vld), W'(1));
        check("full_out_pld", out_pld, rdp(0));
        out_rdy = 1'b1;
        repeat (4) step();
        check("rd4_drained", W'(exp_q.size()), '0);
        check("rd4_cnt", W'(rd_cnt), '0);
        check("rd4_out_vld", W'(out_vld), '0);
        out_rdy = 1'b0;

        // Starvation: continuous reads with one waiting write.
        rd_req_vld = 1'b1; rd_req_pld = rdp(100);
        wr_req_vld = 1'b1; wr_req_pld = wrp(0);
        step();
        wr_req_vld = 1'b0;
        for (int i = 1; i < 4; i++) begin
            rd_req_pld = rdp(100 + i);
            step();
        end
        for (int i = 0; i < 8; i++) expect_out(rdp(100 + i), 1'b0);
        expect_out(wrp(0), 1'b1);
        for (int i = 8; i < 12; i++) expect_out(rdp(100 + i), 1'b0);
        out_rdy = 1'b1;
        idx = 4;
        rd_req_pld = rdp(100 + idx);
        for (int cyc = 0; cyc < 80 && (idx < 12 || exp_q.size() != 0); cyc++) begin
            acc = rd_req_vld && rd_req_rdy;
            step();
            if (acc) begin
                idx++;
                if (idx == 12) rd_req_vld = 1'b0;
                else rd_req_pld = rdp(100 + idx);
            end
        end
        check("starve_drained", W'(exp_q.size()), '0);
        check("starve_cleared", W'(dut.starve_cnt), '0);
        check("starve_wr_cnt", W'(wr_cnt), '0);
        out_rdy = 1'b0;

        // Held read grant while the write FIFO fills; then full write wins early.
        for (int i = 0; i < 4; i++) begin
            rd_req_vld = (i < 2);
            rd_req_pld = rdp(200 + i);
            wr_req_vld = 1'b1;
            wr_req_pld = wrp(10 + i);
            step();
            check("hold_is_wr", W'(out_is_wr), '0);
            check("hold_pld", out_pld, rdp(200));
        end
        rd_req_vld = 1'b0;
        wr_req_vld = 1'b0;
        check("hold_wr_cnt", W'(wr_cnt), W'(4));
        check("hold_wr_rdy", W'(wr_req_rdy), '0);
        check("hold_rd_cnt", W'(rd_cnt), W'(2));
        step();
        check("hold2_is_wr", W'(out_is_wr), '0);
        check("hold2_pld", out_pld, rdp(200));
        expect_out(rdp(200), 1'b0);
        expect_out(wrp(10), 1'b1);
        expect_out(rdp(201), 1'b0);
        expect_out(wrp(11), 1'b1);
        expect_out(wrp(12), 1'b1);
        expect_out(wrp(13), 1'b1);
        out_rdy = 1'b1;
        drain("wrfull_drained", 20);
        out_rdy = 1'b0;

        // Reset mid-transfer discards buffered requests.
        for (int i = 0; i < 3; i++) begin
            rd_req_vld = 1'b1;
            rd_req_pld = rdp(250 + i);
            wr_req_vld = (i < 2);
            wr_req_pld = wrp(50 + i);
            step();
        end
        rd_req_vld = 1'b0;
        wr_req_vld = 1'b0;
        check("pre_rst_rd_cnt", W'(rd_cnt), W'(3));
        check("pre_rst_wr_cnt", W'(wr_cnt), W'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_out_vld", W'(out_vld), '0);
        check("mid_rst_rd_cnt", W'(rd_cnt), '0);
        check("mid_rst_wr_cnt", W'(wr_cnt), '0);
        rd_req_vld = 1'b1;
        rd_req_pld = rdp(300);
        step();
        rd_req_vld = 1'b0;
        check("post_rst_out_vld", W'(out_vld), W'(1));
        check("post_rst_out_pld", out_pld, rdp(300));
        check("post_rst_is_wr", W'(out_is_wr), '0);
        expect_out(rdp(300), 1'b0);
        out_rdy = 1'b1;
        drain("post_rst_drained", 5);
        step();
        check("final_out_vld", W'(out_vld), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
